// File: rtl/spram_be_ctrl.sv
// One-write/one-read RAM with byte enables, selectable read latency and collision
// behaviour, plus a clear engine that zeroes every word after reset or on request.
module spram_be_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int RD_LATENCY = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_req,
  input  logic                      wr_en,
  input  logic [ADDR_WIDTH-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic                      rd_en,
  input  logic [ADDR_WIDTH-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      init_done,
  output logic                      addr_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  wr_err_q, wr_err_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_err_q, s1_err_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  logic                  run, accept, wr_in_range, rd_in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    run         = (state_q == ST_RUN);
    accept      = run && !clr_req;
    wr_in_range = {1'b0, wr_addr} < DEPTH_X;
    rd_in_range = {1'b0, rd_addr} < DEPTH_X;

    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (!run) begin
      clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
      if (clr_ptr_q == LAST_ADDR) state_d = ST_RUN;
    end else if (clr_req) begin
      state_d   = ST_CLEAR;
      clr_ptr_d = '0;
    end

    // The clear engine owns the write port while clearing.
    if (!run) begin
      mem_we    = !rst;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else begin
      mem_we    = !rst && accept && wr_en && wr_in_range;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_be    = wr_be;
    end

    wr_err_d = accept && wr_en && !wr_in_range;

    rd_word = mem[rd_addr];
    if (WRITE_MODE == 1 && wr_en && wr_addr == rd_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[i*8 +: 8] = wr_data[i*8 +: 8];
      end
    end

    s1_valid_d = accept && rd_en;
    s1_err_d   = accept && rd_en && !rd_in_range;
    s1_data_d  = s1_data_q;
    if (accept && rd_en) s1_data_d = rd_in_range ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= '0;
      wr_err_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wr_err_q   <= wr_err_d;
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_data_q  <= s1_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  flush;
      logic                  s2_valid_q, s2_valid_d;
      logic                  s2_err_q, s2_err_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      // A clear request drops whatever read is sitting in the first stage.
      always_comb begin
        flush      = (state_q == ST_RUN) && clr_req;
        s2_valid_d = s1_valid_q && !flush;
        s2_err_d   = s1_err_q && !flush;
        s2_data_d  = s2_valid_d ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_err_q   <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_err_q   <= s2_err_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign rd_valid = s2_valid_q;
      assign rd_data  = s2_data_q;
      assign addr_err = wr_err_q | s2_err_q;
    end else begin : g_lat1
      assign rd_valid = s1_valid_q;
      assign rd_data  = s1_data_q;
      assign addr_err = wr_err_q | s1_err_q;
    end
  endgenerate

  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_spram_be_ctrl.sv
// Drives four configurations of spram_be_ctrl with shared stimulus and checks every
// cycle against a transaction-level model of memory contents and output schedule.
module tb_spram_be_ctrl;
  logic        clk = 1'b0;
  logic        rst, clr_req, wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;

  logic [31:0] rd_data_w   [4];
  logic        rd_valid_w  [4];
  logic        init_done_w [4];
  logic        addr_err_w  [4];

  always #5 clk = ~clk;

  // cfg0: 16/lat1/read-first  cfg1: 16/lat2/write-first
  // cfg2: 12/lat1/write-first cfg3: 12/lat2/read-first
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      spram_be_ctrl #(
        .DATA_WIDTH (32),
        .DEPTH      (gi < 2 ? 16 : 12),
        .ADDR_WIDTH (4),
        .RD_LATENCY (gi % 2 + 1),
        .WRITE_MODE ((gi == 1 || gi == 2) ? 1 : 0)
      ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data_w[gi]),
        .rd_valid  (rd_valid_w[gi]),
        .init_done (init_done_w[gi]),
        .addr_err  (addr_err_w[gi])
      );
    end
  endgenerate

  function automatic int cfg_depth(int c); return (c < 2) ? 16 : 12; endfunction
  function automatic int cfg_lat(int c);   return c % 2 + 1;         endfunction
  function automatic int cfg_wm(int c);    return (c == 1 || c == 2) ? 1 : 0; endfunction

  // Model state: memory image, remaining clear edges, and a schedule of read
  // results keyed by the edge number at which they become visible.
  logic [31:0] m_mem [4][16];
  int          m_clr_left [4];
  bit          sch_v [4][4];
  bit          sch_e [4][4];
  logic [31:0] sch_d [4][4];
  logic [31:0] m_hold [4];
  bit          exp_v [4];
  bit          exp_e [4];
  bit          exp_id [4];
  logic [31:0] exp_d [4];
  int          edge_no = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic void model_reset_mem(int c);
    for (int a = 0; a < 16; a++) m_mem[c][a] = 32'h0;
    for (int s = 0; s < 4; s++) sch_v[c][s] = 1'b0;
    m_clr_left[c] = cfg_depth(c);
  endfunction

  function automatic void model_edge(int c, bit r, bit cr, bit we, logic [3:0] wa,
                                     logic [31:0] wd, logic [3:0] be, bit re, logic [3:0] ra);
    int          dep  = cfg_depth(c);
    int          slot = edge_no % 4;
    int          s;
    bit          werr = 1'b0;
    logic [31:0] v;
    if (r) begin
      model_reset_mem(c);
      m_hold[c] = 32'h0;
    end else if (m_clr_left[c] > 0) begin
      m_clr_left[c]--;
    end else if (cr) begin
      model_reset_mem(c);
    end else begin
      if (re) begin
        v = 32'h0;
        if (int'(ra) < dep) begin
          v = m_mem[c][ra];
          if (cfg_wm(c) == 1 && we && wa == ra) v = merge(v, wd, be);
        end
        s = (edge_no + cfg_lat(c) - 1) % 4;
        sch_v[c][s] = 1'b1;
        sch_d[c][s] = v;
        sch_e[c][s] = (int'(ra) >= dep);
      end
      if (we) begin
        if (int'(wa) < dep) m_mem[c][wa] = merge(m_mem[c][wa], wd, be);
        else werr = 1'b1;
      end
    end
    exp_v[c] = sch_v[c][slot];
    exp_e[c] = werr | (sch_v[c][slot] & sch_e[c][slot]);
    if (sch_v[c][slot]) m_hold[c] = sch_d[c][slot];
    exp_d[c]  = m_hold[c];
    exp_id[c] = (m_clr_left[c] == 0);
    sch_v[c][slot] = 1'b0;
  endfunction

  task automatic step(input bit r, input bit cr, input bit we, input logic [3:0] wa,
                      input logic [31:0] wd, input logic [3:0] be, input bit re,
                      input logic [3:0] ra);
    rst = r; clr_req = cr; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    for (int c = 0; c < 4; c++) model_edge(c, r, cr, we, wa, wd, be, re, ra);
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("c%0d_rd_valid@%0d", c, edge_no), 32'(rd_valid_w[c]), 32'(exp_v[c]));
      check($sformatf("c%0d_rd_data@%0d", c, edge_no), rd_data_w[c], exp_d[c]);
      check($sformatf("c%0d_addr_err@%0d", c, edge_no), 32'(addr_err_w[c]), 32'(exp_e[c]));
      check($sformatf("c%0d_init_done@%0d", c, edge_no), 32'(init_done_w[c]), 32'(exp_id[c]));
    end
    edge_no++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 32'h0, 4'h0, 0, 4'h0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    step(0, 0, 1, a, d, be, 0, 4'h0);
  endtask
  task automatic rd(input logic [3:0] a);
    step(0, 0, 0, 4'h0, 32'h0, 4'h0, 1, a);
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;

    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 4'h0);
    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 4'h0);
    // Requests during the clear must be ignored.
    for (int i = 0; i < 18; i++)
      step(0, i[0], 1, 4'(i), 32'hDEAD_0000 + 32'(i), 4'hF, 1, 4'(i));
    idle(1);

    // Everything reads back as zero after the initial clear.
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(2);

    // Byte-enable merge.
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3);
    check("tp2_c0_merge", rd_data_w[0], 32'hAA22CC44);
    idle(2);

    // Same-address collision: read-first vs write-first.
    wr(4'd5, 32'h12345678, 4'b1111);
    step(0, 0, 1, 4'd5, 32'hFFFFFFFF, 4'b0011, 1, 4'd5);
    check("tp3_c0_read_first", rd_data_w[0], 32'h12345678);
    check("tp3_c2_write_first", rd_data_w[2], 32'h1234FFFF);
    idle(2);

    // Back-to-back reads.
    for (int a = 0; a < 4; a++) wr(4'(a), 32'(a), 4'hF);
    for (int a = 0; a < 4; a++) rd(4'(a));
    idle(3);

    // Out-of-range write and read (out of range only for the 12-word configs).
    wr(4'd13, 32'hCAFEF00D, 4'hF);
    rd(4'd14);
    idle(3);
    wr(4'd15, 32'h0BADBEEF, 4'b1001);
    step(0, 0, 1, 4'd12, 32'h5555AAAA, 4'hF, 1, 4'd15);
    idle(3);

    // Clear request with reads in flight.
    for (int a = 0; a < 12; a++) wr(4'(a), 32'h100 + 32'(a), 4'hF);
    rd(4'd1);
    step(0, 1, 1, 4'd2, 32'hFFFF0000, 4'hF, 1, 4'd2);
    idle(17);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(2);

    // Reset in the middle of a clear restarts the sweep.
    for (int a = 0; a < 12; a++) wr(4'(a), 32'h200 + 32'(a), 4'hF);
    step(0, 1, 0, 4'h0, 32'h0, 4'h0, 0, 4'h0);
    idle(5);
    step(1, 0, 0, 4'h0, 32'h0, 4'h0, 0, 4'h0);
    idle(17);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(2);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] wa, ra;
      bit r, cr;
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      r  = ($urandom_range(0, 399) == 0);
      cr = ($urandom_range(0, 149) == 0);
      step(r, cr, 1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ra);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
